// File: rtl/div_ctrl.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Stalls EX while the result is pending; special cases finish in one cycle.
module div_ctrl #(
  parameter int WORD_WIDTH = 32
) (
  input  logic                  CLK,
  input  logic                  rst,
  input  logic                  start,
  input  logic [1:0]            op,
  input  logic [WORD_WIDTH-1:0] op_a,
  input  logic [WORD_WIDTH-1:0] op_b,
  input  logic                  hold,
  input  logic                  flush,
  output logic                  div_stall,
  output logic                  done,
  output logic [WORD_WIDTH-1:0] res
);

  localparam int CNT_W = $clog2(WORD_WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORD_WIDTH - 1);
  localparam logic [WORD_WIDTH-1:0] MIN_NEG = {1'b1, {(WORD_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, ADJ, DONE} state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [WORD_WIDTH-1:0] rem_q, rem_d;
  logic [WORD_WIDTH-1:0] quo_q, quo_d;
  logic [WORD_WIDTH-1:0] dvs_q, dvs_d;
  logic [WORD_WIDTH-1:0] res_q, res_d;
  logic                  rem_sel_q, rem_sel_d;
  logic                  neg_quo_q, neg_quo_d;
  logic                  neg_rem_q, neg_rem_d;
  logic                  done_q, done_d;

  logic                  is_signed;
  logic [WORD_WIDTH-1:0] abs_a;
  logic [WORD_WIDTH-1:0] abs_b;
  logic [WORD_WIDTH:0]   trial;

  assign is_signed = ~op[0];
  assign abs_a     = (is_signed && op_a[WORD_WIDTH-1]) ? -op_a : op_a;
  assign abs_b     = (is_signed && op_b[WORD_WIDTH-1]) ? -op_b : op_b;
  // The dividend register doubles as the quotient: its MSB feeds the partial remainder.
  assign trial     = {rem_q, quo_q[WORD_WIDTH-1]} - {1'b0, dvs_q};

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    res_d     = res_q;
    rem_sel_d = rem_sel_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;

    case (state_q)
      IDLE: begin
        if (start && !flush) begin
          rem_sel_d = op[1];
          neg_quo_d = is_signed & (op_a[WORD_WIDTH-1] ^ op_b[WORD_WIDTH-1]);
          neg_rem_d = is_signed & op_a[WORD_WIDTH-1];
          rem_d     = '0;
          quo_d     = abs_a;
          dvs_d     = abs_b;
          if (op_b == '0) begin
            res_d   = op[1] ? op_a : '1;
            state_d = DONE;
          end else if (is_signed && op_a == MIN_NEG && op_b == '1) begin
            res_d   = op[1] ? '0 : MIN_NEG;
            state_d = DONE;
          end else begin
            count_d = CNT_LAST;
            state_d = CALC;
          end
        end
      end
      CALC: begin
        if (!trial[WORD_WIDTH]) begin
          rem_d = trial[WORD_WIDTH-1:0];
          quo_d = {quo_q[WORD_WIDTH-2:0], 1'b1};
        end else begin
          rem_d = {rem_q[WORD_WIDTH-2:0], quo_q[WORD_WIDTH-1]};
          quo_d = {quo_q[WORD_WIDTH-2:0], 1'b0};
        end
        if (count_q == '0) begin
          state_d = ADJ;
        end else begin
          count_d = count_q - CNT_W'(1);
        end
      end
      ADJ: begin
        if (rem_sel_q) begin
          res_d = neg_rem_q ? -rem_q : rem_q;
        end else begin
          res_d = neg_quo_q ? -quo_q : quo_q;
        end
        state_d = DONE;
      end
      DONE: begin
        if (!hold) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A redirect kills whatever is in flight but leaves the last result visible.
    if (flush) begin
      state_d = IDLE;
      res_d   = res_q;
    end

    done_d = (state_d == DONE);
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      state_q   <= IDLE;
      count_q   <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      res_q     <= '0;
      rem_sel_q <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      res_q     <= res_d;
      rem_sel_q <= rem_sel_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      done_q    <= done_d;
    end
  end

  assign div_stall = start & ~flush & ~rst & (state_q != DONE);
  assign done      = done_q;
  assign res       = res_q;

endmodule

// File: tb/tb_div_ctrl.sv
// Directed testbench for div_ctrl: vector table plus hold, flush and reset sequences.
module tb_div_ctrl;

  logic        CLK = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        hold;
  logic        flush;
  logic        div_stall;
  logic        done;
  logic [31:0] res;

  int checks = 0;
  int errors = 0;

  div_ctrl #(.WORD_WIDTH(32)) dut (
    .CLK(CLK), .rst(rst), .start(start), .op(op), .op_a(op_a), .op_b(op_b),
    .hold(hold), .flush(flush), .div_stall(div_stall), .done(done), .res(res)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[14];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Entered and left one time unit after a rising edge; leaves start low in the IDLE cycle after DONE.
  task automatic applyStimulus(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                               output logic [31:0] r, output int lat, output logic stall_at_done,
                               output logic done_after, output logic got);
    start = 1'b1;
    op    = o;
    op_a  = a;
    op_b  = b;
    lat   = 0;
    got   = 1'b0;
    r     = '0;
    stall_at_done = 1'b1;
    for (int i = 0; i < 100; i++) begin
      #1;
      if (done) begin
        got = 1'b1;
        r = res;
        stall_at_done = div_stall;
        break;
      end
      if (div_stall) lat++;
      @(posedge CLK);
      #1;
    end
    tick();
    start = 1'b0;
    #1;
    done_after = done;
    #(-0);
  endtask

  logic [31:0] r;
  int          lat;
  logic        sd, da, got;
  int          n;
  logic        saw_done;

  initial begin
    vecs[0]  = '{"div_100_7",       2'd0, 32'd100,      32'd7,        32'd14,        34};
    vecs[1]  = '{"rem_m7_2",        2'd2, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF,  34};
    vecs[2]  = '{"remu_fff9_2",     2'd3, 32'hFFFFFFF9, 32'd2,        32'd1,         34};
    vecs[3]  = '{"divu_5_0",        2'd1, 32'd5,        32'd0,        32'hFFFFFFFF,  1};
    vecs[4]  = '{"rem_5_0",         2'd2, 32'd5,        32'd0,        32'd5,         1};
    vecs[5]  = '{"div_ovf",         2'd0, 32'h80000000, 32'hFFFFFFFF, 32'h80000000,  1};
    vecs[6]  = '{"rem_ovf",         2'd2, 32'h80000000, 32'hFFFFFFFF, 32'd0,         1};
    vecs[7]  = '{"rem_m100_7",      2'd2, 32'hFFFFFF9C, 32'd7,        32'hFFFFFFFE,  34};
    vecs[8]  = '{"divu_max_1",      2'd1, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF,  34};
    vecs[9]  = '{"remu_max_10",     2'd3, 32'hFFFFFFFF, 32'd10,       32'd5,         34};
    vecs[10] = '{"div_7_m2",        2'd0, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD,  34};
    vecs[11] = '{"rem_7_m2",        2'd2, 32'd7,        32'hFFFFFFFE, 32'd1,         34};
    vecs[12] = '{"divu_min_max",    2'd1, 32'h80000000, 32'hFFFFFFFF, 32'd0,         34};
    vecs[13] = '{"div_m1_0",        2'd0, 32'hFFFFFFFF, 32'd0,        32'hFFFFFFFF,  1};

    rst = 1'b1; start = 1'b1; op = 2'd0; op_a = 32'd100; op_b = 32'd7; hold = 1'b0; flush = 1'b0;
    tick();
    tick();
    #1;
    checkOutput("reset stall", {31'd0, div_stall}, 32'd0);
    checkOutput("reset done", {31'd0, done}, 32'd0);
    checkOutput("reset res", res, 32'd0);
    rst = 1'b0;
    start = 1'b0;
    tick();

    $display("[TB] vector table");
    for (int i = 0; i < 14; i++) begin
      applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, r, lat, sd, da, got);
      if (!got) begin
        checks++;
        errors++;
        $display("[TB] FAIL %s timeout actual=no_done required=done", vecs[i].name);
      end
      checkOutput({vecs[i].name, " res"}, r, vecs[i].exp);
      checkOutput({vecs[i].name, " stall_cycles"}, 32'(lat), 32'(vecs[i].lat));
      checkOutput({vecs[i].name, " stall_at_done"}, {31'd0, sd}, 32'd0);
      checkOutput({vecs[i].name, " done_after"}, {31'd0, da}, 32'd0);
    end

    $display("[TB] hold in DONE");
    op = 2'd0; op_a = 32'hFFFFFF9C; op_b = 32'd7; start = 1'b1; n = 0;
    for (int c = 0; c < 34; c++) begin
      #1;
      if (div_stall) n++;
      if (c == 1) begin
        op_a = 32'd5;
        op = 2'd3;
      end
      tick();
    end
    checkOutput("hold stall_cycles", 32'(n), 32'd34);
    hold = 1'b1;
    for (int h = 0; h < 3; h++) begin
      #1;
      checkOutput("hold done", {31'd0, done}, 32'd1);
      checkOutput("hold res", res, 32'hFFFFFFF2);
      checkOutput("hold stall", {31'd0, div_stall}, 32'd0);
      tick();
    end
    hold = 1'b0;
    #1;
    checkOutput("hold last done", {31'd0, done}, 32'd1);
    checkOutput("hold last res", res, 32'hFFFFFFF2);
    tick();
    start = 1'b0;
    #1;
    checkOutput("hold released done", {31'd0, done}, 32'd0);
    tick();

    $display("[TB] flush mid-divide");
    op = 2'd0; op_a = 32'd1000; op_b = 32'd3; start = 1'b1;
    for (int c = 0; c < 10; c++) tick();
    flush = 1'b1;
    #1;
    checkOutput("flush stall", {31'd0, div_stall}, 32'd0);
    tick();
    flush = 1'b0;
    start = 1'b0;
    #1;
    checkOutput("flush done", {31'd0, done}, 32'd0);
    tick();
    op = 2'd1; op_a = 32'd9; op_b = 32'd3; start = 1'b1; saw_done = 1'b0;
    for (int c = 12; c < 46; c++) begin
      #1;
      if (done) saw_done = 1'b1;
      tick();
    end
    checkOutput("flush early done", {31'd0, saw_done}, 32'd0);
    #1;
    checkOutput("after flush done", {31'd0, done}, 32'd1);
    checkOutput("after flush res", res, 32'd3);
    checkOutput("after flush stall", {31'd0, div_stall}, 32'd0);
    tick();
    start = 1'b0;
    tick();

    $display("[TB] reset mid-divide");
    op = 2'd0; op_a = 32'd1000; op_b = 32'd7; start = 1'b1;
    for (int c = 0; c < 20; c++) tick();
    rst = 1'b1;
    #1;
    checkOutput("midrst stall", {31'd0, div_stall}, 32'd0);
    tick();
    rst = 1'b0;
    start = 1'b0;
    #1;
    checkOutput("midrst done", {31'd0, done}, 32'd0);
    checkOutput("midrst res", res, 32'd0);
    tick();
    applyStimulus(2'd1, 32'd1000, 32'd3, r, lat, sd, da, got);
    checkOutput("post rst res", r, 32'd333);
    checkOutput("post rst stall_cycles", 32'(lat), 32'd34);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
